alu_op_sequencer: RTL and testbench

//  Issue side of the datapath ALU. Accepts operation requests on a valid/ready channel and

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_sel_decoder.sv | 35 +++
 rtl/alu_op_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings: select codes, funct/ALUOp fields, response error codes and
// sequencer FSM states.
package alu_pkg;

   localparam logic [3:0] SEL_AND  = 4'b0000;
   localparam logic [3:0] SEL_OR   = 4'b0001;
   localparam logic [3:0] SEL_ADD  = 4'b0010;
   localparam logic [3:0] SEL_NOR  = 4'b0100;
   localparam logic [3:0] SEL_MUL  = 4'b0101;
   localparam logic [3:0] SEL_SUB  = 4'b0110;
   localparam logic [3:0] SEL_XOR  = 4'b0111;
   localparam logic [3:0] SEL_DIV  = 4'b1000;
   localparam logic [3:0] SEL_SLT  = 4'b1001;
   localparam logic [3:0] SEL_ZERO = 4'b1101;
   localparam logic [3:0] SEL_ONES = 4'b1111;

   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;
   localparam logic [5:0] FUNCT_XOR = 6'h26;
   localparam logic [5:0] FUNCT_NOR = 6'h27;
   localparam logic [5:0] FUNCT_SLT = 6'h2A;
   localparam logic [5:0] FUNCT_MUL = 6'h18;
   localparam logic [5:0] FUNCT_DIV = 6'h1A;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_SLT   = 2'b11;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_DIV0    = 2'b10;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

endpackage

// File: rtl/alu_sel_decoder.sv
// Combinational {ALUOp, funct} -> ALU select decode with an illegal-op flag.
module alu_sel_decoder
   import alu_pkg::*;
(
   input  logic [1:0] aluop_i,
   input  logic [5:0] funct_i,
   output logic [3:0] sel_o,
   output logic       illegal_o
);

   always_comb begin
      sel_o     = SEL_ZERO;
      illegal_o = 1'b0;
      unique case (aluop_i)
         ALUOP_ADD: sel_o = SEL_ADD;
         ALUOP_SUB: sel_o = SEL_SUB;
         ALUOP_SLT: sel_o = SEL_SLT;
         default: begin
            case (funct_i)
               FUNCT_ADD: sel_o = SEL_ADD;
               FUNCT_SUB: sel_o = SEL_SUB;
               FUNCT_AND: sel_o = SEL_AND;
               FUNCT_OR:  sel_o = SEL_OR;
               FUNCT_XOR: sel_o = SEL_XOR;
               FUNCT_NOR: sel_o = SEL_NOR;
               FUNCT_SLT: sel_o = SEL_SLT;
               FUNCT_MUL: sel_o = SEL_MUL;
               FUNCT_DIV: sel_o = SEL_DIV;
               default:   illegal_o = 1'b1;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue side of the datapath ALU: accepts a request, drives the ALU, waits for settle,
// captures res/zf and holds a registered response until it is consumed.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int DATA_W        = 32,
   parameter int SETTLE_CYCLES = 1
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_aluop,
   input  logic [5:0]        req_funct,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_sel,
   input  logic [DATA_W-1:0] alu_res,
   input  logic              alu_zf,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_res,
   output logic              rsp_zf,
   output logic [1:0]        rsp_err
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [3:0]        alu_sel_q, alu_sel_d;
   logic [1:0]        pend_err_q, pend_err_d;
   logic [DATA_W-1:0] rsp_res_q, rsp_res_d;
   logic              rsp_zf_q, rsp_zf_d;
   logic [1:0]        rsp_err_q, rsp_err_d;

   logic [3:0] dec_sel;
   logic       dec_illegal;

   alu_sel_decoder u_dec (
      .aluop_i   (req_aluop),
      .funct_i   (req_funct),
      .sel_o     (dec_sel),
      .illegal_o (dec_illegal)
   );

   // Rejected ops still take one pass through ISSUE (with the ALU left idle) so their
   // response appears one edge after accept, like a single-cycle settle.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_sel_d  = alu_sel_q;
      pend_err_d = pend_err_q;
      rsp_res_d  = rsp_res_q;
      rsp_zf_d   = rsp_zf_q;
      rsp_err_d  = rsp_err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d = ST_ISSUE;
               if (dec_illegal) begin
                  pend_err_d = ERR_ILLEGAL;
                  cnt_d      = '0;
               end else if (dec_sel == SEL_DIV && req_b == '0) begin
                  pend_err_d = ERR_DIV0;
                  cnt_d      = '0;
               end else begin
                  pend_err_d = ERR_OK;
                  alu_a_d    = req_a;
                  alu_b_d    = req_b;
                  alu_sel_d  = dec_sel;
                  cnt_d      = CNT_INIT;
               end
            end
         end
         ST_ISSUE: begin
            if (cnt_q == '0) begin
               state_d   = ST_RESP;
               rsp_err_d = pend_err_q;
               alu_sel_d = SEL_ZERO;
               if (pend_err_q == ERR_OK) begin
                  rsp_res_d = alu_res;
                  rsp_zf_d  = alu_zf;
               end else begin
                  rsp_res_d = '0;
                  rsp_zf_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_sel_q  <= SEL_ZERO;
         pend_err_q <= ERR_OK;
         rsp_res_q  <= '0;
         rsp_zf_q   <= 1'b0;
         rsp_err_q  <= ERR_OK;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_sel_q  <= alu_sel_d;
         pend_err_q <= pend_err_d;
         rsp_res_q  <= rsp_res_d;
         rsp_zf_q   <= rsp_zf_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_sel   = alu_sel_q;
   assign rsp_res   = rsp_res_q;
   assign rsp_zf    = rsp_zf_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (settle 1 and 3), each driving a behavioural ALU.
module tb_alu_op_sequencer;

   localparam int W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Instance with SETTLE_CYCLES=1
   logic         rst1_n, req_valid1, req_ready1, rsp_valid1, rsp_ready1, rsp_zf1, alu_zf1;
   logic [1:0]   req_aluop1, rsp_err1;
   logic [5:0]   req_funct1;
   logic [3:0]   alu_sel1;
   logic [W-1:0] req_a1, req_b1, alu_a1, alu_b1, alu_res1, rsp_res1;

   // Instance with SETTLE_CYCLES=3
   logic         rst3_n, req_valid3, req_ready3, rsp_valid3, rsp_ready3, rsp_zf3, alu_zf3;
   logic [1:0]   req_aluop3, rsp_err3;
   logic [5:0]   req_funct3;
   logic [3:0]   alu_sel3;
   logic [W-1:0] req_a3, req_b3, alu_a3, alu_b3, alu_res3, rsp_res3;

   function automatic logic [W-1:0] alu_f(input logic [3:0] sel, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      case (sel)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0100: return ~(a | b);
         4'b0101: return a * b;
         4'b0110: return a - b;
         4'b0111: return a ^ b;
         4'b1000: return (b == '0) ? '0 : a / b;
         4'b1001: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
         4'b1111: return '1;
         default: return '0;
      endcase
   endfunction

   assign alu_res1 = alu_f(alu_sel1, alu_a1, alu_b1);
   assign alu_zf1  = (alu_res1 == '0);
   assign alu_res3 = alu_f(alu_sel3, alu_a3, alu_b3);
   assign alu_zf3  = (alu_res3 == '0);

   alu_op_sequencer #(.DATA_W(W), .SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst1_n), .req_valid(req_valid1), .req_ready(req_ready1),
      .req_aluop(req_aluop1), .req_funct(req_funct1), .req_a(req_a1), .req_b(req_b1),
      .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1), .alu_res(alu_res1),
      .alu_zf(alu_zf1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
      .rsp_res(rsp_res1), .rsp_zf(rsp_zf1), .rsp_err(rsp_err1)
   );

   alu_op_sequencer #(.DATA_W(W), .SETTLE_CYCLES(3)) dut3 (
      .clk(clk), .rst_n(rst3_n), .req_valid(req_valid3), .req_ready(req_ready3),
      .req_aluop(req_aluop3), .req_funct(req_funct3), .req_a(req_a3), .req_b(req_b3),
      .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3), .alu_res(alu_res3),
      .alu_zf(alu_zf3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
      .rsp_res(rsp_res3), .rsp_zf(rsp_zf3), .rsp_err(rsp_err3)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: what the operation means, straight from the opcode tables.
   task automatic ref_op(input logic [1:0] aluop, input logic [5:0] funct,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [3:0] sel, output logic [W-1:0] res,
                         output logic zf, output logic [1:0] err);
      err = 2'b00;
      sel = 4'b1101;
      res = '0;
      case (aluop)
         2'b00: begin sel = 4'b0010; res = a + b; end
         2'b01: begin sel = 4'b0110; res = a - b; end
         2'b11: begin sel = 4'b1001; res = (int'(a) < int'(b)) ? 1 : 0; end
         default: begin
            case (funct)
               6'h20: begin sel = 4'b0010; res = a + b; end
               6'h22: begin sel = 4'b0110; res = a - b; end
               6'h24: begin sel = 4'b0000; res = a & b; end
               6'h25: begin sel = 4'b0001; res = a | b; end
               6'h26: begin sel = 4'b0111; res = a ^ b; end
               6'h27: begin sel = 4'b0100; res = ~(a | b); end
               6'h2A: begin sel = 4'b1001; res = (int'(a) < int'(b)) ? 1 : 0; end
               6'h18: begin sel = 4'b0101; res = W'(longint'(a) * longint'(b)); end
               6'h1A: begin
                  sel = 4'b1000;
                  if (b == 0) err = 2'b10;
                  else res = a / b;
               end
               default: err = 2'b01;
            endcase
         end
      endcase
      if (err != 2'b00) res = '0;
      zf = (err == 2'b00) && (res == '0);
   endtask

   // One complete transaction on the settle-1 instance, holding off the consumer for `hold` cycles.
   task automatic op1(input logic [1:0] aluop, input logic [5:0] funct,
                      input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
      logic [3:0]   e_sel;
      logic [W-1:0] e_res;
      logic         e_zf;
      logic [1:0]   e_err;
      int           edges;
      ref_op(aluop, funct, a, b, e_sel, e_res, e_zf, e_err);
      chk("idle_ready", {63'd0, req_ready1}, 64'd1);
      req_valid1 = 1'b1; req_aluop1 = aluop; req_funct1 = funct; req_a1 = a; req_b1 = b;
      step();
      req_valid1 = 1'b0; req_a1 = $urandom; req_b1 = $urandom; req_funct1 = 6'($urandom);
      chk("busy_ready", {63'd0, req_ready1}, 64'd0);
      chk("sel_issue", {60'd0, alu_sel1}, (e_err == 2'b00) ? {60'd0, e_sel} : 64'hD);
      if (e_err == 2'b00) begin
         chk("alu_a", {32'd0, alu_a1}, {32'd0, a});
         chk("alu_b", {32'd0, alu_b1}, {32'd0, b});
      end
      edges = 0;
      while (!rsp_valid1 && edges < 20) begin
         step();
         edges++;
      end
      chk("latency", 64'(edges), 64'd1);
      chk("rsp_res", {32'd0, rsp_res1}, {32'd0, e_res});
      chk("rsp_zf", {63'd0, rsp_zf1}, {63'd0, e_zf});
      chk("rsp_err", {62'd0, rsp_err1}, {62'd0, e_err});
      chk("sel_after", {60'd0, alu_sel1}, 64'hD);
      for (int i = 0; i < hold; i++) begin
         step();
         chk("hold_valid", {63'd0, rsp_valid1}, 64'd1);
         chk("hold_res", {32'd0, rsp_res1}, {32'd0, e_res});
         chk("hold_ready", {63'd0, req_ready1}, 64'd0);
      end
      rsp_ready1 = 1'b1;
      step();
      rsp_ready1 = 1'b0;
      chk("rsp_drop", {63'd0, rsp_valid1}, 64'd0);
   endtask

   logic [5:0] legal_f [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h18, 6'h1A};

   initial begin
      int edges;
      logic [1:0]   r_op;
      logic [5:0]   r_f;
      logic [W-1:0] r_a, r_b;

      rst1_n = 1'b0; req_valid1 = 1'b0; rsp_ready1 = 1'b0;
      req_aluop1 = '0; req_funct1 = '0; req_a1 = '0; req_b1 = '0;
      rst3_n = 1'b0; req_valid3 = 1'b0; rsp_ready3 = 1'b0;
      req_aluop3 = '0; req_funct3 = '0; req_a3 = '0; req_b3 = '0;
      step();
      req_valid1 = 1'b1;
      step();
      chk("rst_ready", {63'd0, req_ready1}, 64'd1);
      chk("rst_valid", {63'd0, rsp_valid1}, 64'd0);
      chk("rst_sel", {60'd0, alu_sel1}, 64'hD);
      chk("rst_a", {32'd0, alu_a1}, 64'd0);
      chk("rst_b", {32'd0, alu_b1}, 64'd0);
      chk("rst_res", {32'd0, rsp_res1}, 64'd0);
      chk("rst_zf_err", {61'd0, rsp_zf1, rsp_err1}, 64'd0);
      req_valid1 = 1'b0;
      rst1_n = 1'b1; rst3_n = 1'b1;
      step();

      op1(2'b10, 6'h20, 32'd5, 32'd7, 0);
      op1(2'b01, 6'h00, 32'd9, 32'd9, 0);
      op1(2'b10, 6'h1A, 32'd10, 32'd0, 0);
      op1(2'b10, 6'h3F, 32'd11, 32'd12, 0);
      op1(2'b10, 6'h1A, 32'd100, 32'd7, 1);
      op1(2'b11, 6'h00, 32'hFFFF_FFFF, 32'd1, 0);

      // Backpressure with a second request waiting behind the response
      req_valid1 = 1'b1; req_aluop1 = 2'b10; req_funct1 = 6'h2A; req_a1 = 32'd3; req_b1 = 32'd4;
      step();
      req_aluop1 = 2'b00; req_a1 = 32'd1; req_b1 = 32'd2;
      step();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", {63'd0, rsp_valid1}, 64'd1);
         chk("bp_res", {32'd0, rsp_res1}, 64'd1);
         chk("bp_ready", {63'd0, req_ready1}, 64'd0);
         step();
      end
      rsp_ready1 = 1'b1;
      step();
      rsp_ready1 = 1'b0;
      chk("bp_hs_valid", {63'd0, rsp_valid1}, 64'd0);
      chk("bp_hs_ready", {63'd0, req_ready1}, 64'd1);
      step();
      req_valid1 = 1'b0;
      chk("bp_next_sel", {60'd0, alu_sel1}, 64'h2);
      chk("bp_next_a", {32'd0, alu_a1}, 64'd1);
      step();
      chk("bp_next_res", {32'd0, rsp_res1}, 64'd3);
      rsp_ready1 = 1'b1;
      step();
      rsp_ready1 = 1'b0;

      for (int n = 0; n < 40; n++) begin
         r_op = 2'($urandom_range(0, 3));
         r_f  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_f[$urandom_range(0, 8)];
         r_a  = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 50)) : W'($urandom);
         r_b  = ($urandom_range(0, 3) == 0) ? '0 :
                ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 50)) : W'($urandom);
         op1(r_op, r_f, r_a, r_b, $urandom_range(0, 3));
      end

      // Settle-3 instance: 6*7 takes three edges
      req_valid3 = 1'b1; req_aluop3 = 2'b10; req_funct3 = 6'h18; req_a3 = 32'd6; req_b3 = 32'd7;
      step();
      req_valid3 = 1'b0; req_a3 = 32'd99;
      chk("s3_sel", {60'd0, alu_sel3}, 64'h5);
      edges = 0;
      while (!rsp_valid3 && edges < 20) begin
         step();
         edges++;
         if (!rsp_valid3) chk("s3_sel_hold", {60'd0, alu_sel3}, 64'h5);
      end
      chk("s3_latency", 64'(edges), 64'd3);
      chk("s3_res", {32'd0, rsp_res3}, 64'd42);
      chk("s3_zf_err", {61'd0, rsp_zf3, rsp_err3}, 64'd0);
      rsp_ready3 = 1'b1;
      step();
      rsp_ready3 = 1'b0;

      // Divide by zero is rejected one edge after accept even with a longer settle
      req_valid3 = 1'b1; req_funct3 = 6'h1A; req_a3 = 32'd8; req_b3 = 32'd0;
      step();
      req_valid3 = 1'b0;
      step();
      chk("s3_div0_valid", {63'd0, rsp_valid3}, 64'd1);
      chk("s3_div0_err", {62'd0, rsp_err3}, 64'd2);
      chk("s3_div0_sel", {60'd0, alu_sel3}, 64'hD);
      rsp_ready3 = 1'b1;
      step();
      rsp_ready3 = 1'b0;

      // Reset while in ISSUE discards the operation
      req_valid3 = 1'b1; req_funct3 = 6'h18; req_a3 = 32'd2; req_b3 = 32'd3;
      step();
      req_valid3 = 1'b0;
      step();
      chk("s3_mid_busy", {63'd0, req_ready3}, 64'd0);
      #2 rst3_n = 1'b0;
      #1;
      chk("s3_rst_valid", {63'd0, rsp_valid3}, 64'd0);
      chk("s3_rst_sel", {60'd0, alu_sel3}, 64'hD);
      chk("s3_rst_ready", {63'd0, req_ready3}, 64'd1);
      chk("s3_rst_a", {32'd0, alu_a3}, 64'd0);
      step();
      rst3_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("s3_no_rsp", {63'd0, rsp_valid3}, 64'd0);
      end
      chk("s3_idle", {63'd0, req_ready3}, 64'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
